mp_add_sequencer: RTL

//  Word-serial multi-precision adder stage. Accepts operands one WIDTH-bit word per beat, LS word first.

---
 rtl/mp_add_pkg.sv | 30 +++
 rtl/nbitadder.sv | 25 ++
 rtl/mp_add_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/mp_add_pkg.sv
// Shared helpers for the word-serial multi-precision adder: counter sizing and
// the FIRST/MID/LAST word-phase encoding.
package mp_add_pkg;

    localparam logic [1:0] PH_FIRST = 2'd0;
    localparam logic [1:0] PH_MID   = 2'd1;
    localparam logic [1:0] PH_LAST  = 2'd2;

    // Bits needed to count 0..n-1, never less than one so the counter always exists.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // LAST wins over FIRST so a single-word operand is always flagged last.
    function automatic logic [1:0] word_phase(input int idx, input int nwords);
        if (idx == nwords - 1) begin
            return PH_LAST;
        end else if (idx == 0) begin
            return PH_FIRST;
        end else begin
            return PH_MID;
        end
    endfunction

endpackage

// File: rtl/nbitadder.sv
// Plain WIDTH-bit ripple-carry adder, fully combinational.
module nbitadder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision adder: one WIDTH-bit word per beat, LS word first,
// carry held between beats. Define MP_ADD_OVF_EN to add the out_ovf signed-overflow output.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             cin_init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout
`ifdef MP_ADD_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int IDX_W = clog2_min1(NWORDS);

    logic [IDX_W-1:0] word_idx_reg;
    logic             carry_reg;
    logic             acc;
    logic             is_first;
    logic             is_last;
    logic [1:0]       phase;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign phase    = word_phase(int'(word_idx_reg), NWORDS);
    assign is_first = (word_idx_reg == '0);
    assign is_last  = (phase == PH_LAST);

    // A single output register with no skid buffer: accept only if it is empty or draining.
    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;
    assign add_cin  = is_first ? cin_init : carry_reg;

    nbitadder #(.WIDTH(WIDTH)) u_add (
        .a    (in_a),
        .b    (in_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef MP_ADD_OVF_EN
    logic msb_cin;
    assign msb_cin = in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ add_sum[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_reg <= '0;
            carry_reg    <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_last     <= 1'b0;
            out_cout     <= 1'b0;
`ifdef MP_ADD_OVF_EN
            out_ovf      <= 1'b0;
`endif
        end else if (clear) begin
            word_idx_reg <= '0;
            carry_reg    <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_cout     <= 1'b0;
`ifdef MP_ADD_OVF_EN
            out_ovf      <= 1'b0;
`endif
        end else if (acc) begin
            out_sum      <= add_sum;
            out_valid    <= 1'b1;
            carry_reg    <= add_cout;
            out_last     <= is_last;
            out_cout     <= is_last ? add_cout : 1'b0;
`ifdef MP_ADD_OVF_EN
            out_ovf      <= is_last ? (msb_cin ^ add_cout) : 1'b0;
`endif
            word_idx_reg <= is_last ? '0 : word_idx_reg + IDX_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule
